uart_switcher_sync: RTL and testbench

Registered, glitch-free successor to the combinational UART crossbar between the shell UART and PITON_N Piton UARTs. All lines run in the piton_clk domain. A channel-select change takes effect only after both directions of the current link have been idle for a programmable time, or after a timeout. Unselected Piton receivers are held at the UART idle level (1) rather than driven low.

---
 rtl/uart_switcher_pkg.sv | 13 +
 rtl/uart_sync_bit.sv | 26 ++
 rtl/uart_switcher_sync.sv | 164 ++++++++++++++++
 tb/tb_uart_switcher_sync.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_switcher_pkg.sv
// Shared types and idle-level constants for the synchronous UART switcher.
package uart_switcher_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } sw_state_e;

  localparam logic UART_IDLE = 1'b1;
  localparam logic CTS_IDLE  = 1'b0;

endpackage

// File: rtl/uart_sync_bit.sv
// Multi-flop synchroniser for asynchronous inputs, with a configurable reset level.
module uart_sync_bit #(
  parameter int unsigned STAGES  = 2,
  parameter int unsigned WIDTH   = 1,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < STAGES; s++) stage_q[s] <= {WIDTH{RST_VAL}};
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/uart_switcher_sync.sv
// Glitch-free shell<->Piton UART crossbar: a select change waits for an idle link
// (or a timeout), then spends one cycle with every output at its idle level.
module uart_switcher_sync
  import uart_switcher_pkg::*;
#(
  parameter int unsigned PITON_N       = 4,
  parameter int unsigned PITON_N_LOG   = 2,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned IDLE_CYCLES   = 1024,
  parameter int unsigned DRAIN_TIMEOUT = 65536
) (
  input  logic                   piton_clk,
  input  logic                   rst,
  input  logic [PITON_N-1:0]     piton_tx,
  output logic [PITON_N-1:0]     piton_rx,
  input  logic                   shell_tx,
  output logic                   shell_rx,
  input  logic [PITON_N-1:0]     piton_rts,
  output logic [PITON_N-1:0]     piton_cts,
  input  logic                   shell_rts,
  output logic                   shell_cts,
  input  logic [PITON_N_LOG-1:0] sw,
  output logic [PITON_N_LOG-1:0] cur_sel,
  output logic                   busy,
  output logic                   forced
);

  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(DRAIN_TIMEOUT + 1);

  logic [PITON_N-1:0]     piton_tx_s, piton_rts_s;
  logic                   shell_tx_s, shell_rts_s;
  logic [PITON_N_LOG-1:0] req_s;

  uart_sync_bit #(.STAGES(SYNC_STAGES), .WIDTH(PITON_N_LOG), .RST_VAL(1'b0)) u_sync_sw (
    .clk_i(piton_clk), .rst_i(rst), .d_i(sw), .q_o(req_s));
  uart_sync_bit #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_shell_tx (
    .clk_i(piton_clk), .rst_i(rst), .d_i(shell_tx), .q_o(shell_tx_s));
  uart_sync_bit #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0)) u_sync_shell_rts (
    .clk_i(piton_clk), .rst_i(rst), .d_i(shell_rts), .q_o(shell_rts_s));

  for (genvar i = 0; i < int'(PITON_N); i++) begin : g_piton_sync
    uart_sync_bit #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_tx (
      .clk_i(piton_clk), .rst_i(rst), .d_i(piton_tx[i]), .q_o(piton_tx_s[i]));
    uart_sync_bit #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0)) u_sync_rts (
      .clk_i(piton_clk), .rst_i(rst), .d_i(piton_rts[i]), .q_o(piton_rts_s[i]));
  end

  sw_state_e              state_q, state_d;
  logic [PITON_N_LOG-1:0] cur_sel_q, cur_sel_d, tgt_q, tgt_d, req_eff;
  logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d, idle_inc;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d, to_inc;
  logic                   forced_q, forced_d, busy_q, busy_d;
  logic                   req_valid, cur_tx, link_idle, link_on;
  logic                   shell_rx_q, shell_rx_d, shell_cts_q, shell_cts_d;
  logic [PITON_N-1:0]     piton_rx_q, piton_rx_d, piton_cts_q, piton_cts_d;

  // Out-of-range requests fold onto the current channel so they never start a drain.
  always_comb begin
    req_valid = 1'b0;
    cur_tx    = UART_IDLE;
    for (int unsigned i = 0; i < PITON_N; i++) begin
      if (req_s == PITON_N_LOG'(i)) req_valid = 1'b1;
      if (cur_sel_q == PITON_N_LOG'(i)) cur_tx = piton_tx_s[i];
    end
    req_eff   = req_valid ? req_s : cur_sel_q;
    link_idle = shell_tx_s & cur_tx;
    idle_inc  = (idle_cnt_q == IDLE_W'(IDLE_CYCLES)) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
    to_inc    = (to_cnt_q == TO_W'(DRAIN_TIMEOUT)) ? to_cnt_q : to_cnt_q + TO_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    tgt_d      = tgt_q;
    forced_d   = forced_q;
    idle_cnt_d = idle_cnt_q;
    to_cnt_d   = to_cnt_q;
    unique case (state_q)
      ACTIVE: begin
        if (req_eff != cur_sel_q) begin
          state_d    = DRAIN;
          idle_cnt_d = '0;
          to_cnt_d   = '0;
        end
      end
      DRAIN: begin
        idle_cnt_d = link_idle ? idle_inc : '0;
        to_cnt_d   = to_inc;
        if (req_eff == cur_sel_q) begin
          state_d = ACTIVE;
        end else if (link_idle && idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1)) begin
          state_d  = SWITCH;
          tgt_d    = req_eff;
          forced_d = 1'b0;
        end else if (to_cnt_q == TO_W'(DRAIN_TIMEOUT - 1)) begin
          state_d  = SWITCH;
          tgt_d    = req_eff;
          forced_d = 1'b1;
        end
      end
      SWITCH: begin
        cur_sel_d = tgt_q;
        state_d   = ACTIVE;
      end
      default: state_d = ACTIVE;
    endcase
    busy_d = (state_d != ACTIVE);
  end

  // Output mux looks at next state/select so the link registers align with the FSM.
  always_comb begin
    link_on     = (state_d != SWITCH);
    shell_rx_d  = UART_IDLE;
    shell_cts_d = CTS_IDLE;
    piton_rx_d  = {PITON_N{UART_IDLE}};
    piton_cts_d = {PITON_N{CTS_IDLE}};
    for (int unsigned i = 0; i < PITON_N; i++) begin
      if (link_on && cur_sel_d == PITON_N_LOG'(i)) begin
        shell_rx_d     = piton_tx_s[i];
        shell_cts_d    = piton_rts_s[i];
        piton_rx_d[i]  = shell_tx_s;
        piton_cts_d[i] = shell_rts_s;
      end
    end
  end

  always_ff @(posedge piton_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACTIVE;
      cur_sel_q   <= '0;
      tgt_q       <= '0;
      forced_q    <= 1'b0;
      busy_q      <= 1'b0;
      idle_cnt_q  <= '0;
      to_cnt_q    <= '0;
      shell_rx_q  <= UART_IDLE;
      shell_cts_q <= CTS_IDLE;
      piton_rx_q  <= {PITON_N{UART_IDLE}};
      piton_cts_q <= {PITON_N{CTS_IDLE}};
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      tgt_q       <= tgt_d;
      forced_q    <= forced_d;
      busy_q      <= busy_d;
      idle_cnt_q  <= idle_cnt_d;
      to_cnt_q    <= to_cnt_d;
      shell_rx_q  <= shell_rx_d;
      shell_cts_q <= shell_cts_d;
      piton_rx_q  <= piton_rx_d;
      piton_cts_q <= piton_cts_d;
    end
  end

  assign shell_rx  = shell_rx_q;
  assign shell_cts = shell_cts_q;
  assign piton_rx  = piton_rx_q;
  assign piton_cts = piton_cts_q;
  assign cur_sel   = cur_sel_q;
  assign busy      = busy_q;
  assign forced    = forced_q;

endmodule

// File: tb/tb_uart_switcher_sync.sv
// Bench for uart_switcher_sync: directed scenarios plus random traffic against a delay-line reference model.
module tb_uart_switcher_sync;

  localparam int N    = 4;
  localparam int LW   = 3;
  localparam int SS   = 2;
  localparam int IDLE = 16;
  localparam int TO   = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  piton_tx, piton_rx, piton_rts, piton_cts;
  logic          shell_tx, shell_rx, shell_rts, shell_cts;
  logic [LW-1:0] sw, cur_sel;
  logic          busy, forced;

  uart_switcher_sync #(
    .PITON_N(N), .PITON_N_LOG(LW), .SYNC_STAGES(SS), .IDLE_CYCLES(IDLE), .DRAIN_TIMEOUT(TO)
  ) dut (
    .piton_clk(clk), .rst(rst),
    .piton_tx(piton_tx), .piton_rx(piton_rx),
    .shell_tx(shell_tx), .shell_rx(shell_rx),
    .piton_rts(piton_rts), .piton_cts(piton_cts),
    .shell_rts(shell_rts), .shell_cts(shell_cts),
    .sw(sw), .cur_sel(cur_sel), .busy(busy), .forced(forced)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the switcher sees every input SS cycles late.
  typedef struct packed {
    logic [N-1:0]  ptx;
    logic [N-1:0]  prts;
    logic          stx;
    logic          srts;
    logic [LW-1:0] sw;
  } snap_t;

  snap_t hist[$];
  int    m_sel, m_target, m_age, m_run;
  bit    m_drain, m_switch, m_forced;
  logic  e_shell_rx, e_shell_cts;
  logic [N-1:0] e_piton_rx, e_piton_cts;

  task automatic model_reset();
    snap_t r;
    r.ptx = '1; r.prts = '0; r.stx = 1'b1; r.srts = 1'b0; r.sw = '0;
    hist = {};
    for (int i = 0; i < SS; i++) hist.push_back(r);
    m_sel = 0; m_target = 0; m_age = 0; m_run = 0;
    m_drain = 0; m_switch = 0; m_forced = 0;
    e_shell_rx = 1'b1; e_shell_cts = 1'b0; e_piton_rx = '1; e_piton_cts = '0;
  endtask

  task automatic model_step(input snap_t now);
    snap_t v;
    int    want;
    bit    idle;
    hist.push_back(now);
    v = hist.pop_front();
    want = (int'(v.sw) < N) ? int'(v.sw) : m_sel;
    if (m_switch) begin
      m_sel    = m_target;
      m_switch = 0;
    end else if (m_drain) begin
      idle  = v.stx && v.ptx[m_sel];
      m_run = idle ? m_run + 1 : 0;
      m_age = m_age + 1;
      if (want == m_sel) m_drain = 0;
      else if (m_run >= IDLE) begin m_drain = 0; m_switch = 1; m_target = want; m_forced = 0; end
      else if (m_age >= TO)   begin m_drain = 0; m_switch = 1; m_target = want; m_forced = 1; end
    end else if (want != m_sel) begin
      m_drain = 1; m_run = 0; m_age = 0;
    end
    e_shell_rx = 1'b1; e_shell_cts = 1'b0; e_piton_rx = '1; e_piton_cts = '0;
    if (!m_switch) begin
      e_shell_rx          = v.ptx[m_sel];
      e_shell_cts         = v.prts[m_sel];
      e_piton_rx[m_sel]   = v.stx;
      e_piton_cts[m_sel]  = v.srts;
    end
  endtask

  task automatic compare_all();
    check("shell_rx", shell_rx, e_shell_rx);
    check("shell_cts", shell_cts, e_shell_cts);
    check("piton_rx", piton_rx, e_piton_rx);
    check("piton_cts", piton_cts, e_piton_cts);
    check("cur_sel", cur_sel, m_sel);
    check("busy", busy, m_drain || m_switch);
    check("forced", forced, m_forced);
  endtask

  // Inputs held since the last negedge are taken by the coming posedge.
  task automatic tick();
    snap_t now;
    now.ptx = piton_tx; now.prts = piton_rts; now.stx = shell_tx; now.srts = shell_rts; now.sw = sw;
    @(negedge clk);
    model_step(now);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel"}, cur_sel, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_forced"}, forced, 0);
    check({tag, "_srx"}, shell_rx, 1);
    check({tag, "_prx"}, piton_rx, 4'hF);
    check({tag, "_pcts"}, piton_cts, 0);
    check({tag, "_scts"}, shell_cts, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_values("rst_async");
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  task automatic all_idle();
    piton_tx = '1; shell_tx = 1'b1;
  endtask

  bit noisy;
  int k;

  initial begin
    rst = 1'b1;
    piton_tx = '1; shell_tx = 1'b1; piton_rts = '0; shell_rts = 1'b0; sw = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_values("reset");
    compare_all();

    // shell_tx reaches piton_rx[0] after SS+1 cycles
    repeat (4) tick();
    shell_tx = 1'b0;
    tick(); tick();
    check("tx_lat2", piton_rx, 4'hF);
    tick();
    check("tx_lat3", piton_rx, 4'hE);
    shell_tx = 1'b1;
    repeat (4) tick();

    // clean switch to channel 2
    all_idle(); shell_rts = 1'b1; piton_rts = '1;
    repeat (4) tick();
    sw = 3'd2;
    tick(); tick();
    check("busy_lat2", busy, 0);
    tick();
    check("busy_lat3", busy, 1);
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (t == 16) begin
        check("sw_cycle_sel", cur_sel, 0);
        check("sw_cycle_prx", piton_rx, 4'hF);
        check("sw_cycle_pcts", piton_cts, 0);
        check("sw_cycle_scts", shell_cts, 0);
      end
    end
    check("clean_sel", cur_sel, 2);
    check("clean_forced", forced, 0);
    check("clean_pcts", piton_cts, 4'b0100);

    // glitchy link forces a timeout switch back to 0
    sw = 3'd0;
    for (int t = 0; t < 3 + 65; t++) begin
      piton_tx[2] = (t % 10 == 0) ? 1'b0 : 1'b1;
      tick();
      if (t + 1 == 3) check("to_busy", busy, 1);
      if (t + 1 == 3 + 64) begin
        check("to_switch_sel", cur_sel, 2);
        check("to_switch_prx", piton_rx, 4'hF);
      end
    end
    check("to_sel", cur_sel, 0);
    check("to_forced", forced, 1);

    // clean switch clears forced
    all_idle();
    sw = 3'd1;
    repeat (20) tick();
    check("clr_sel", cur_sel, 1);
    check("clr_forced", forced, 0);

    // aborted request: no switch
    sw = 3'd3;
    repeat (8) tick();
    check("abort_busy", busy, 1);
    sw = 3'd1;
    tick(); tick();
    check("abort_busy2", busy, 1);
    tick();
    check("abort_idle", busy, 0);
    repeat (20) tick();
    check("abort_sel", cur_sel, 1);

    // out-of-range select is ignored
    sw = 3'd5;
    for (int t = 0; t < 10; t++) begin
      tick();
      check("oor_busy", busy, 0);
    end
    check("oor_sel", cur_sel, 1);

    // RTS/CTS routing on channel 1
    sw = 3'd1; piton_rts = '0; shell_rts = 1'b0;
    repeat (4) tick();
    piton_rts = 4'b0010;
    tick(); tick();
    check("cts_lat2", shell_cts, 0);
    tick();
    check("cts_lat3", shell_cts, 1);
    shell_rts = 1'b1;
    tick(); tick();
    check("pcts_lat2", piton_cts, 0);
    tick();
    check("pcts_lat3", piton_cts, 4'b0010);

    // reset in the middle of a drain cancels the pending switch
    sw = 3'd3;
    repeat (8) tick();
    check("rst_pre_busy", busy, 1);
    sw = 3'd0;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      tick();
      check("post_rst_busy", busy, 0);
    end
    check("post_rst_sel", cur_sel, 0);

    // random traffic
    noisy = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) noisy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) sw = 3'($urandom_range(0, 7));
      if (noisy) begin
        piton_tx = 4'($urandom);
        shell_tx = 1'($urandom);
      end else begin
        all_idle();
        if ($urandom_range(0, 30) == 0) begin
          k = $urandom_range(0, N - 1);
          piton_tx[k] = 1'b0;
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        piton_rts = 4'($urandom);
        shell_rts = 1'($urandom);
      end
      if (c == 1500) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
